// File: rtl/bram_dump_reader_pkg.sv
// Shared types and sizing helpers for the BRAM dump reader.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package bram_dump_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  function automatic int bytes_per_word(input int ram_width);
    return ram_width / 8;
  endfunction

  // One bit minimum so an 8-bit word still gets a legal index vector
  function automatic int byte_idx_w(input int ram_width);
    return (ram_width / 8 > 1) ? $clog2(ram_width / 8) : 1;
  endfunction

  function automatic bit ram_width_ok(input int ram_width);
    return (ram_width > 0) && (ram_width % 8 == 0);
  endfunction

endpackage

// File: rtl/bram_dump_reader_word_serializer.sv
// Holds one BRAM word and presents it as bytes, least-significant first.
// Latency: byte 0 valid the cycle after load; one byte per cycle while tx_rdy is high.
// Backpressure: tx_rdy low freezes tx_vld and tx_dat until the byte is taken.
module bram_dump_reader_word_serializer
  import bram_dump_reader_pkg::*;
#(
  parameter int RAM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_vld,
  input  logic [RAM_WIDTH-1:0] load_dat,
  output logic [7:0]           tx_dat,
  output logic                 tx_vld,
  input  logic                 tx_rdy,
  output logic                 last_acc
);

  localparam int BYTES_PER_WORD = bytes_per_word(RAM_WIDTH);
  localparam int IDX_W          = byte_idx_w(RAM_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [RAM_WIDTH-1:0] sh_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 vld_q;

  assign tx_dat   = sh_q[7:0];
  assign tx_vld   = vld_q;
  assign last_acc = vld_q && tx_rdy && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else if (load_vld) begin
      sh_q  <= load_dat;
      idx_q <= '0;
      vld_q <= 1'b1;
    end else if (vld_q && tx_rdy) begin
      sh_q  <= sh_q >> 8;
      idx_q <= idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bram_dump_reader.sv
// Dumps BRAM words 0..N_WORDS-1 as a byte stream over valid/ready.
// Latency: first byte valid 3 cycles after start; 2 + RAM_WIDTH/8 cycles per word at full rate.
// Backpressure: i_tx_ready low stalls the current byte; no further BRAM reads until the word drains.
module bram_dump_reader
  import bram_dump_reader_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_NBIT = 15,
  parameter int N_WORDS       = 2**RAM_ADDR_NBIT - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_mem_done,
  output logic                     o_read,
  output logic [RAM_ADDR_NBIT-1:0] o_addr,
  input  logic [RAM_WIDTH-1:0]     i_rdata,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  if (!ram_width_ok(RAM_WIDTH)) begin : g_bad_width
    $error("bram_dump_reader: RAM_WIDTH must be a positive multiple of 8");
  end

  localparam logic [RAM_ADDR_NBIT-1:0] LAST_WORD = RAM_ADDR_NBIT'(N_WORDS - 1);

  state_t                   state_q, state_d;
  logic [RAM_ADDR_NBIT-1:0] word_cnt_q, word_cnt_d;
  logic                     last_acc;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && i_mem_done) begin
          state_d    = S_REQ;
          word_cnt_d = '0;
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: state_d = S_SEND;
      S_SEND: begin
        if (last_acc) begin
          if (word_cnt_q == LAST_WORD) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_REQ;
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-port and status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      o_read     <= 1'b0;
      o_addr     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      o_read     <= (state_d == S_REQ);
      if (state_d == S_REQ) begin
        o_addr <= word_cnt_d;
      end
      o_busy     <= (state_d != S_IDLE) && (state_d != S_DONE);
      o_done     <= (state_d == S_DONE);
    end
  end

  bram_dump_reader_word_serializer #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_vld (state_q == S_WAIT),
    .load_dat (i_rdata),
    .tx_dat   (o_tx_data),
    .tx_vld   (o_tx_valid),
    .tx_rdy   (i_tx_ready),
    .last_acc (last_acc)
  );

endmodule

// File: tb/tb_bram_dump_reader.sv
// Bench for bram_dump_reader: small-memory instance for dump behaviour, default instance for the address boundary.
`timescale 1ns/1ps
module tb_bram_dump_reader;

  localparam int W  = 32;
  localparam int AS = 3;
  localparam int NS = 2**AS - 1;
  localparam int AB = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // small instance
  logic          start_s = 1'b0, mem_done_s = 1'b0, tx_ready_s = 1'b0;
  logic          read_s, tx_valid_s, busy_s, done_s;
  logic [AS-1:0] addr_s;
  logic [W-1:0]  rdata_s = '0;
  logic [7:0]    tx_data_s;
  logic [W-1:0]  mem_s [NS+1];

  // default-parameter instance
  logic          start_b = 1'b0, mem_done_b = 1'b0, tx_ready_b = 1'b0;
  logic          read_b, tx_valid_b, busy_b, done_b;
  logic [AB-1:0] addr_b;
  logic [W-1:0]  rdata_b = '0;
  logic [7:0]    tx_data_b;

  bram_dump_reader #(.RAM_WIDTH(W), .RAM_ADDR_NBIT(AS), .N_WORDS(NS)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_start(start_s), .i_mem_done(mem_done_s),
    .o_read(read_s), .o_addr(addr_s), .i_rdata(rdata_s),
    .o_tx_data(tx_data_s), .o_tx_valid(tx_valid_s), .i_tx_ready(tx_ready_s),
    .o_busy(busy_s), .o_done(done_s));

  bram_dump_reader dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_mem_done(mem_done_b),
    .o_read(read_b), .o_addr(addr_b), .i_rdata(rdata_b),
    .o_tx_data(tx_data_b), .o_tx_valid(tx_valid_b), .i_tx_ready(tx_ready_b),
    .o_busy(busy_b), .o_done(done_b));

  // BRAM models: data appears the cycle after the read strobe is sampled
  always @(posedge clk) if (read_s) rdata_s <= mem_s[addr_s];
  always @(posedge clk) if (read_b) rdata_b <= 32'hC0DE_0000 | {17'b0, addr_b};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // monitors record what crossed the link and the BRAM port
  logic [7:0] got_s[$], got_b[$];
  int got_cyc_s[$], got_cyc_b[$], reads_s[$], reads_b[$];
  int done_cnt_s = 0, done_cyc_s = 0, done_busy_s = 0;
  int done_cnt_b = 0, done_cyc_b = 0, done_busy_b = 0;
  logic pv_s = 0, pr_s = 0, pv_b = 0, pr_b = 0;
  logic [7:0] pd_s = 0, pd_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv_s = 1'b0;
    end else begin
      if (pv_s && !pr_s) begin
        check("stall_valid_s", tx_valid_s, 1);
        check("stall_data_s", tx_data_s, pd_s);
      end
      if (tx_valid_s && tx_ready_s) begin got_s.push_back(tx_data_s); got_cyc_s.push_back(cyc); end
      if (read_s) reads_s.push_back(int'(addr_s));
      if (done_s) begin done_cnt_s++; done_cyc_s = cyc; done_busy_s = int'(busy_s); end
      pv_s = tx_valid_s; pr_s = tx_ready_s; pd_s = tx_data_s;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pv_b = 1'b0;
    end else begin
      if (pv_b && !pr_b) begin
        check("stall_valid_b", tx_valid_b, 1);
        check("stall_data_b", tx_data_b, pd_b);
      end
      if (tx_valid_b && tx_ready_b) begin got_b.push_back(tx_data_b); got_cyc_b.push_back(cyc); end
      if (read_b) reads_b.push_back(int'(addr_b));
      if (done_b) begin done_cnt_b++; done_cyc_b = cyc; done_busy_b = int'(busy_b); end
      pv_b = tx_valid_b; pr_b = tx_ready_b; pd_b = tx_data_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_s();
    got_s.delete(); got_cyc_s.delete(); reads_s.delete();
    done_cnt_s = 0; done_busy_s = 0;
  endtask

  task automatic check_idle_s(input string tag);
    check({tag, "_read"}, read_s, 0);
    check({tag, "_addr"}, addr_s, 0);
    check({tag, "_tx_data"}, tx_data_s, 0);
    check({tag, "_tx_valid"}, tx_valid_s, 0);
    check({tag, "_busy"}, busy_s, 0);
    check({tag, "_done"}, done_s, 0);
  endtask

  // pulse i_start for one edge; returns the cycle stamp of the sampling edge
  task automatic start_s_pulse(output int start_cyc);
    start_s = 1'b1;
    mem_done_s = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start_s = 1'b0;
  endtask

  // run until o_done with random ready at 'duty' percent; poke>=0 re-requests start mid-dump
  task automatic run_s(input int duty, input int budget, input int poke);
    int k = 0;
    while (done_cnt_s == 0 && k < budget) begin
      tx_ready_s = ($urandom_range(0, 99) < duty);
      start_s = (k == poke);
      if (poke >= 0 && k >= poke + 5) mem_done_s = 1'b0;
      tick();
      k++;
    end
    check("done_within_budget_s", int'(done_cnt_s != 0), 1);
    start_s = 1'b0;
    tx_ready_s = 1'b1;
    repeat (6) tick();
    mem_done_s = 1'b1;
  endtask

  // reference: every word 0..NS-1, LSB byte first; one read per word; one o_done
  task automatic check_dump_s(input string tag);
    logic [7:0] exp[$];
    for (int a = 0; a < NS; a++)
      for (int b = 0; b < W/8; b++)
        exp.push_back(8'(mem_s[a] >> (8*b)));
    check({tag, "_nbytes"}, got_s.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_s.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_s[i], exp[i]);
    check({tag, "_nreads"}, reads_s.size(), NS);
    for (int i = 0; i < NS && i < reads_s.size(); i++)
      check($sformatf("%s_read_addr%0d", tag, i), reads_s[i], i);
    check({tag, "_ndone"}, done_cnt_s, 1);
    check({tag, "_busy_at_done"}, done_busy_s, 0);
    check({tag, "_busy_after"}, busy_s, 0);
  endtask

  typedef struct {
    logic start;
    logic mem_done;
    logic exp_busy;
    logic exp_read;
  } gate_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    gate_vec_t gv[4];
    int sc;
    int k;
    gv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    gv[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
    gv[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    gv[3] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // reset state
    #12;
    check_idle_s("reset_s");
    check("reset_busy_b", busy_b, 0);
    check("reset_valid_b", tx_valid_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // normal dump
    for (int a = 0; a <= NS; a++) mem_s[a] = 32'h0000_1000 + a;
    clear_s();
    tx_ready_s = 1'b1;
    start_s_pulse(sc);
    check("req_read", read_s, 1);
    check("req_addr", addr_s, 0);
    check("req_busy", busy_s, 1);
    tick();
    check("wait_read", read_s, 0);
    check("wait_valid", tx_valid_s, 0);
    tick();
    check("send_valid", tx_valid_s, 1);
    check("send_byte0", tx_data_s, 8'h00);
    run_s(100, 200, -1);
    check("normal_latency", done_cyc_s - sc + 1, 43);
    check_dump_s("normal");

    // start gating table
    for (int i = 0; i < 4; i++) begin
      clear_s();
      start_s = gv[i].start;
      mem_done_s = gv[i].mem_done;
      tick();
      start_s = 1'b0;
      check($sformatf("gate%0d_busy", i), busy_s, gv[i].exp_busy);
      check($sformatf("gate%0d_read", i), read_s, gv[i].exp_read);
      if (gv[i].exp_busy) begin
        run_s(100, 200, -1);
        check_dump_s($sformatf("gate%0d", i));
      end else begin
        repeat (4) tick();
        check($sformatf("gate%0d_noreads", i), reads_s.size(), 0);
        check($sformatf("gate%0d_idle_busy", i), busy_s, 0);
      end
      mem_done_s = 1'b1;
    end

    // second start and mem_done drop mid-dump are ignored
    clear_s();
    start_s_pulse(sc);
    run_s(100, 200, 10);
    check_dump_s("restart_ignored");

    // backpressure with a known word, then random contents and duty
    mem_s[0] = 32'hDEAD_BEEF;
    for (int a = 1; a <= NS; a++) mem_s[a] = $urandom;
    clear_s();
    start_s_pulse(sc);
    run_s(30, 3000, -1);
    check_dump_s("bp30");
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a <= NS; a++) mem_s[a] = $urandom;
      clear_s();
      start_s_pulse(sc);
      run_s($urandom_range(20, 80), 3000, -1);
      check_dump_s($sformatf("rand%0d", r));
    end

    // reset during SEND after 5 bytes
    for (int a = 0; a <= NS; a++) mem_s[a] = $urandom;
    clear_s();
    tx_ready_s = 1'b1;
    start_s_pulse(sc);
    k = 0;
    while (got_s.size() < 5 && k < 100) begin tick(); k++; end
    check("five_bytes_seen", got_s.size(), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_s("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    clear_s();
    start_s_pulse(sc);
    run_s(100, 200, -1);
    check_dump_s("after_reset");

    // boundary on default parameters: counter forced near the top
    got_b.delete(); got_cyc_b.delete(); reads_b.delete(); done_cnt_b = 0;
    tx_ready_b = 1'b0;
    start_b = 1'b1;
    mem_done_b = 1'b1;
    tick();
    start_b = 1'b0;
    k = 0;
    while (!tx_valid_b && k < 10) begin tick(); k++; end
    check("big_first_valid", tx_valid_b, 1);
    force dut_b.word_cnt_q = 15'h7FFD;
    tick();
    release dut_b.word_cnt_q;
    tx_ready_b = 1'b1;
    k = 0;
    while (done_cnt_b == 0 && k < 100) begin tick(); k++; end
    repeat (5) tick();
    check("big_nreads", reads_b.size(), 2);
    if (reads_b.size() == 2) begin
      check("big_read0", reads_b[0], 0);
      check("big_read_last", reads_b[1], 32'h7FFE);
    end
    check("big_nbytes", got_b.size(), 8);
    for (int i = 0; i < 8 && i < got_b.size(); i++)
      check($sformatf("big_byte%0d", i), got_b[i],
            8'(((i < 4) ? 32'hC0DE_0000 : 32'hC0DE_7FFE) >> (8*(i%4))));
    check("big_ndone", done_cnt_b, 1);
    if (got_cyc_b.size() > 0)
      check("big_done_after_last", done_cyc_b - got_cyc_b[got_cyc_b.size()-1], 1);
    check("big_busy_at_done", done_busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
